// File: rtl/data_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : data_mem_arbiter_if
// Request, response and memory-side signals of the two-port data memory arbiter.
// Rev    : 1.0
// ============================================================================
interface data_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 8
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              ack0;
  logic              ack1;
  logic              err0;
  logic              err1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic              busy;
  logic              mem_WE;
  logic              mem_RE;
  logic [ADDR_W-1:0] mem_Dir;
  logic [DATA_W-1:0] mem_Data;
  logic [DATA_W-1:0] mem_Data_out;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_Data_out,
    output ack0, ack1, err0, err1, rdata0, rdata1, busy,
           mem_WE, mem_RE, mem_Dir, mem_Data
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_Data_out,
    input  ack0, ack1, err0, err1, rdata0, rdata1, busy,
           mem_WE, mem_RE, mem_Dir, mem_Data
  );
endinterface
`default_nettype wire

// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : data_mem_arbiter
// Round-robin arbiter/sequencer serializing two requesters onto one memory port.
// Rev    : 1.0
// ============================================================================
module data_mem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 8,
  parameter int MEM_DEPTH = 8
) (
  input wire                 clk,
  input wire                 rst,
  data_mem_arbiter_if.slave  bus
);

  localparam logic [ADDR_W-1:0] c_mem_depth = ADDR_W'(MEM_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_owner;
  logic              r_last_owner;
  logic              r_we;
  logic              r_reject;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;

  logic              w_req_any;
  logic              w_grant1;
  logic [ADDR_W-1:0] w_sel_addr;

  assign w_req_any  = bus.req0 | bus.req1;
  // Port 1 wins when alone, or when contested and port 0 was the last owner.
  assign w_grant1   = bus.req1 & (~bus.req0 | ~r_last_owner);
  assign w_sel_addr = w_grant1 ? bus.addr1 : bus.addr0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_req_any) w_next = S_ACCESS;
      S_ACCESS: w_next = S_WAIT;
      S_WAIT:   w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner      <= 1'b0;
      r_last_owner <= 1'b1;
      r_we         <= 1'b0;
      r_reject     <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
    end else begin
      if (r_state == S_IDLE && w_req_any) begin
        r_owner      <= w_grant1;
        r_last_owner <= w_grant1;
        r_we         <= w_grant1 ? bus.we1 : bus.we0;
        r_addr       <= w_sel_addr;
        r_wdata      <= w_grant1 ? bus.wdata1 : bus.wdata0;
        r_reject     <= (w_sel_addr >= c_mem_depth);
      end
      // Memory registered the read at the end of ACCESS; capture it here.
      if (r_state == S_WAIT && !r_we && !r_reject) begin
        if (r_owner) begin
          r_rdata1 <= bus.mem_Data_out;
        end else begin
          r_rdata0 <= bus.mem_Data_out;
        end
      end
    end
  end

  assign bus.busy     = (r_state != S_IDLE);
  assign bus.ack0     = (r_state == S_DONE) & ~r_owner;
  assign bus.ack1     = (r_state == S_DONE) &  r_owner;
  assign bus.err0     = (r_state == S_DONE) & ~r_owner & r_reject;
  assign bus.err1     = (r_state == S_DONE) &  r_owner & r_reject;
  assign bus.rdata0   = r_rdata0;
  assign bus.rdata1   = r_rdata1;
  assign bus.mem_WE   = ~((r_state == S_ACCESS) &  r_we & ~r_reject);
  assign bus.mem_RE   = ~((r_state == S_ACCESS) & ~r_we & ~r_reject);
  assign bus.mem_Dir  = r_addr;
  assign bus.mem_Data = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_data_mem_arbiter
// Self-checking bench: vector table plus scoreboarded multi-cycle sequences.
// Rev    : 1.0
// ============================================================================
module tb_data_mem_arbiter;
  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 8;
  localparam int MEM_DEPTH = 8;
  localparam int AW        = $clog2(MEM_DEPTH);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  data_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory: write on negedge while mem_WE low, registered read on posedge.
  logic [7:0] mem [MEM_DEPTH] = '{default: 8'h00};
  always @(negedge clk)
    if (!bus.mem_WE && bus.mem_Dir < MEM_DEPTH) mem[bus.mem_Dir[AW-1:0]] <= bus.mem_Data;
  always @(posedge clk)
    if (!bus.mem_RE && bus.mem_Dir < MEM_DEPTH) bus.mem_Data_out <= mem[bus.mem_Dir[AW-1:0]];

  typedef struct {
    bit         port;
    bit         err;
    logic [7:0] rd;
  } exp_t;

  typedef struct {
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [7:0]  wdata;
    bit          err;
    logic [7:0]  rd;
  } vec_t;

  exp_t sb[$];
  exp_t e_mon;
  vec_t vecs[10];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int we_low   = 0;
  int re_low   = 0;
  int bad_strobe = 0;
  int last_ack_cyc = -1;
  bit sat_mode = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  function automatic void fail(input string name);
    n_checks++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endfunction

  // Strobe accounting and ack scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (!bus.mem_WE) we_low++;
    if (!bus.mem_RE) re_low++;
    if ((!bus.mem_WE || !bus.mem_RE) && (bus.mem_Dir >= MEM_DEPTH || (!bus.mem_WE && !bus.mem_RE)))
      bad_strobe++;
    if (bus.ack0 && bus.ack1) begin
      fail("dual_ack");
    end else if (bus.ack0 || bus.ack1) begin
      if (sb.size() == 0) begin
        fail("unexpected_ack");
      end else begin
        e_mon = sb.pop_front();
        check("ack_port", 32'(bus.ack1), 32'(e_mon.port));
        check("err", 32'(bus.ack1 ? bus.err1 : bus.err0), 32'(e_mon.err));
        check("err_other", 32'(bus.ack1 ? bus.err0 : bus.err1), 32'd0);
        check("rdata", 32'(bus.ack1 ? bus.rdata1 : bus.rdata0), 32'(e_mon.rd));
        if (sat_mode) begin
          if (last_ack_cyc >= 0) check("ack_spacing", cyc - last_ack_cyc, 32'd4);
          last_ack_cyc = cyc;
        end
      end
    end
  end

  task automatic drive(input bit port, input bit req, input bit we,
                       input logic [31:0] a, input logic [7:0] d);
    if (port) begin
      bus.req1 = req; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
    end else begin
      bus.req0 = req; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
    end
  endtask

  task automatic txn(input bit port, input bit we, input logic [31:0] a, input logic [7:0] d,
                     input bit err, input logic [7:0] rd, input bit chk_lat);
    int start;
    bit got;
    sb.push_back('{port, err, rd});
    @(posedge clk); #1;
    drive(port, 1'b1, we, a, d);
    start = cyc;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (port ? bus.ack1 : bus.ack0) got = 1'b1;
    end
    if (!got) fail("ack_timeout");
    else if (chk_lat) check("latency", cyc - start, 32'd3);
    drive(port, 1'b0, 1'b0, 32'd0, 8'd0);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic sat_port(input bit port);
    int n = 0;
    for (int i = 0; i < 100 && n < 4; i++) begin
      @(negedge clk);
      if (port ? bus.ack1 : bus.ack0) n++;
    end
    if (n < 4) fail("sat_timeout");
    drive(port, 1'b0, 1'b0, 32'd0, 8'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, r0, a1, a2, start;
    bit got;

    vecs[0] = '{1'b0, 1'b1, 32'd3,          8'hA5, 1'b0, 8'h00};
    vecs[1] = '{1'b0, 1'b0, 32'd3,          8'h00, 1'b0, 8'hA5};
    vecs[2] = '{1'b1, 1'b1, 32'd7,          8'h5A, 1'b0, 8'h00};
    vecs[3] = '{1'b1, 1'b0, 32'd7,          8'h00, 1'b0, 8'h5A};
    vecs[4] = '{1'b0, 1'b1, 32'd0,          8'h11, 1'b0, 8'hA5};
    vecs[5] = '{1'b1, 1'b0, 32'd0,          8'h00, 1'b0, 8'h11};
    vecs[6] = '{1'b1, 1'b1, 32'd8,          8'hEE, 1'b1, 8'h11};
    vecs[7] = '{1'b1, 1'b0, 32'hFFFF_FFFF,  8'h00, 1'b1, 8'h11};
    vecs[8] = '{1'b0, 1'b0, 32'd8,          8'h00, 1'b1, 8'hA5};
    vecs[9] = '{1'b0, 1'b0, 32'd7,          8'h00, 1'b0, 8'h5A};

    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 8'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 8'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy",   32'(bus.busy),   32'd0);
    check("rst_ack",    32'({bus.ack0, bus.ack1, bus.err0, bus.err1}), 32'd0);
    check("rst_rdata",  32'({bus.rdata0, bus.rdata1}), 32'd0);
    check("rst_strobe", 32'({bus.mem_WE, bus.mem_RE}), 32'd3);
    check("rst_dir",    bus.mem_Dir, 32'd0);
    check("rst_data",   32'(bus.mem_Data), 32'd0);

    // Single transactions from the table, including range rejects.
    foreach (vecs[k]) begin
      w0 = we_low; r0 = re_low;
      txn(vecs[k].port, vecs[k].we, vecs[k].addr, vecs[k].wdata, vecs[k].err, vecs[k].rd, 1'b1);
      check("we_strobe_cycles", we_low - w0, 32'(vecs[k].we && !vecs[k].err));
      check("re_strobe_cycles", re_low - r0, 32'(!vecs[k].we && !vecs[k].err));
    end
    check("mem_addr7", 32'(mem[7]), 32'h5A);

    // Saturated contention after reset: strict 0,1,0,1 grants, one per 4 cycles.
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{1'b0, 1'b0, 8'hA5});
      sb.push_back('{1'b1, 1'b0, 8'h5A});
    end
    sat_mode = 1'b1;
    last_ack_cyc = -1;
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 32'd3, 8'd0);
    drive(1'b1, 1'b1, 1'b0, 32'd7, 8'd0);
    fork
      sat_port(1'b0);
      sat_port(1'b1);
    join
    sat_mode = 1'b0;

    // Port 1 reads the address port 0 is writing; it must see the new data.
    fork
      txn(1'b0, 1'b1, 32'd2, 8'h3C, 1'b0, 8'hA5, 1'b1);
      begin
        @(posedge clk);
        txn(1'b1, 1'b0, 32'd2, 8'h00, 1'b0, 8'h3C, 1'b0);
      end
    join

    // Reset during ACCESS of a port-0 read.
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 32'd3, 8'd0);
    @(posedge clk); #1;
    check("access_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 8'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_busy",   32'(bus.busy), 32'd0);
    check("midrst_ack",    32'(bus.ack0), 32'd0);
    check("midrst_rdata",  32'(bus.rdata0), 32'd0);
    check("midrst_strobe", 32'({bus.mem_WE, bus.mem_RE}), 32'd3);
    repeat (5) @(negedge clk);
    txn(1'b0, 1'b0, 32'd3, 8'h00, 1'b0, 8'hA5, 1'b1);

    // Port 0 keeps req high through ack, presenting a new command.
    sb.push_back('{1'b0, 1'b0, 8'hA5});
    sb.push_back('{1'b0, 1'b0, 8'h77});
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b1, 32'd5, 8'h77);
    start = cyc;
    a1 = -1; a2 = -1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (bus.ack0) begin got = 1'b1; a1 = cyc; end
    end
    drive(1'b0, 1'b1, 1'b0, 32'd5, 8'h00);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (bus.ack0) begin got = 1'b1; a2 = cyc; end
    end
    drive(1'b0, 1'b0, 1'b0, 32'd0, 8'd0);
    check("hold_first_latency", a1 - start, 32'd3);
    check("hold_second_gap", a2 - a1, 32'd4);
    repeat (8) @(negedge clk);

    check("bad_strobe", bad_strobe, 32'd0);
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
Two-port round-robin arbiter and sequencer for the filter processor's byte-wide data memory. Port 0 serves the processor core and port 1 serves the image/coefficient loader. The block serializes their read and write requests onto the single memory port. It drives the memory's active-low read and write strobes, returns read data, and acknowledges every transaction. Out-of-range addresses are rejected without touching the memory.

Parameters:
ADDR_W, 32, width of request and memory address.
DATA_W, 8, width of data bus.
MEM_DEPTH, 8, number of valid memory words; legal addresses are 0 to MEM_DEPTH-1.

Ports:
clk  in  1  system clock; all logic on posedge.
rst  in  1  synchronous, active-high reset.
req0, req1  in  1  request from port 0 / port 1; held high until ack.
we0, we1  in  1  1 = write, 0 = read; must be stable while req is high.
addr0, addr1  in  ADDR_W  request address.
wdata0, wdata1  in  DATA_W  write data.
ack0, ack1  out  1  one-cycle completion pulse.
err0, err1  out  1  high with ack when the address was out of range.
rdata0, rdata1  out  DATA_W  read data; valid from the ack cycle and held until the next read on that port.
busy  out  1  high whenever state != IDLE.
mem_WE  out  1  active-low write strobe to memory.
mem_RE  out  1  active-low read strobe to memory.
mem_Dir  out  ADDR_W  memory address.
mem_Data  out  DATA_W  memory write data.
mem_Data_out  in  DATA_W  memory read data; registered by the memory on posedge.

Behaviour:
- Reset (synchronous, rst high at posedge):
  - state=IDLE; ack*/err*=0; rdata*=0; busy=0.
  - mem_WE=mem_RE=1; mem_Dir=0; mem_Data=0.
  - last_owner=1, so port 0 wins the first contested arbitration.
- FSM states: IDLE -> ACCESS -> WAIT -> DONE -> IDLE. All outputs are decoded from registers only; there are no combinational paths from req to mem_*.
- IDLE:
  - If any req is high at the posedge, select an owner and latch owner, we, addr and wdata into the command registers. Next state is ACCESS.
  - Arbitration rule:
    - Only one req high: that port wins.
    - Both high: the port != last_owner wins.
    - last_owner updates only on a grant.
  - Range check at latch time: addr >= MEM_DEPTH sets the internal reject flag.
- ACCESS (exactly 1 cycle):
  - mem_Dir = latched addr; mem_Data = latched wdata.
  - Read: mem_RE=0 and mem_WE=1. The memory samples the read on the posedge ending ACCESS.
  - Write: mem_WE=0 and mem_RE=1. The memory writes on the negedge inside ACCESS.
  - Reject: both strobes stay 1.
- WAIT (1 cycle):
  - Strobes return to 1; mem_Dir is held.
  - mem_Data_out is valid during this cycle. For a non-rejected read, rdata<owner> is loaded at the posedge ending WAIT.
- DONE (1 cycle):
  - ack<owner>=1.
  - err<owner>=reject.
  - The other port's ack/err stay 0.
- Requester rule: drop req, or present a new command, at the posedge ending its ack cycle. A req still high in the following IDLE is treated as a new request.
- Latency and throughput:
  - 4 cycles per transaction, counting from the IDLE sample edge to the end of DONE.
  - Back-to-back requests give one transaction per 4 cycles.
  - With both ports saturated, grants alternate strictly 0,1,0,1.
- Width rules:
  - Full ADDR_W compare against MEM_DEPTH.
  - No address truncation or wrap-around; an out-of-range address is rejected, not aliased.
- Reset mid-operation:
  - rst during ACCESS of a write: the memory's negedge write has already occurred and is not undone.
  - The FSM returns to IDLE with no ack, and the requester must re-issue.
  - rst during WAIT or DONE: ack is suppressed and rdata is cleared to 0.
- req on the owning port is ignored outside IDLE. A req arriving on the other port while busy waits, with no loss.

Test Plan:
1. Reset, then port0 writes 0xA5 to addr 3, then port0 reads addr 3 -> each transaction gives ack0 on cycle 4 after the req edge; mem_WE low exactly during write ACCESS; rdata0=0xA5 at the read ack; err0=0.
2. req0 and req1 rise together, both reads, repeated 4 times -> grant order 0,1,0,1; ack0 and ack1 never in the same cycle; one ack every 4 cycles.
3. Port1 writes addr 8 (MEM_DEPTH=8), then port1 reads addr 0xFFFFFFFF -> both strobes stay high throughout; ack1=err1=1; rdata1 unchanged; memory contents unchanged.
4. Port1 reads addr 2 while port0 is mid-write to addr 2 -> port1 is granted after port0's DONE; rdata1 equals port0's new write data.
5. Assert rst for 1 cycle during ACCESS of a port0 read -> next cycle IDLE with busy=0, no ack0, rdata0=0, strobes high; a re-issued read completes normally.
6. Port0 holds req high through ack with a new command -> second transaction starts in the IDLE after DONE; no duplicate ack for the first command.
